memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of DEFAULT_TYPE words; addresses at or above MEM_DEPTH SHALL alias modulo MEM_DEPTH.
REQ-002 Parameter IO_OUT_ADDR, default 8'hFF: memory-mapped output address.
REQ-003 Parameter CLEAR_ON_RESET, default 1: 1 SHALL run the CLEAR sweep after reset; 0 SHALL go straight to READY.
REQ-004 CLOCK  input  1  single clock; all state SHALL update on posedge CLOCK.
REQ-005 RESET  input  1  reset is synchronous and active-high.
REQ-006 ctrl_bus  input  MEMORY_FLAG_TYPE  MEMORY_READ / MEMORY_WRITE / MEMORY_STAY from CPU.
REQ-007 addr_bus  input  DEFAULT_TYPE (8)  access address.
REQ-008 write_bus  input  DEFAULT_TYPE (8)  write data.
REQ-009 read_bus  output  DEFAULT_TYPE (8)  registered read data to CPU.
REQ-010 load_valid  input  1  bench/loader write strobe.
REQ-011 load_addr  input  8  loader address.
REQ-012 load_data  input  8  loader data.
REQ-013 mem_ready  output  1  high only in READY.
REQ-014 io_out  output  8  last value written to IO_OUT_ADDR.
REQ-015 write_count  output  8  saturating count of accepted CPU writes.

Function
REQ-016 FSM states SHALL be CLEAR and READY (MEMORY_STATE_TYPE).
REQ-017 CLEAR: one word per cycle, clear_ptr 0..MEM_DEPTH-1 set to 8'h00; after the write to MEM_DEPTH-1, next state SHALL be READY (MEM_DEPTH cycles total).
REQ-018 In CLEAR, ctrl_bus, load_valid and the io_out/write_count registers SHALL be ignored and read_bus SHALL hold 8'h00.
REQ-019 READY, ctrl_bus==MEMORY_READ: read_bus SHALL equal mem[addr_bus] on the following cycle (latency 1, read-before-write semantics).
REQ-020 READY, ctrl_bus==MEMORY_WRITE: mem[addr_bus] SHALL become write_bus at the edge; read_bus SHALL hold its value.
REQ-021 READY, ctrl_bus==MEMORY_STAY or any unlisted encoding: no array change; read_bus SHALL hold.
REQ-022 load_valid in READY SHALL write load_data to mem[load_addr]; it SHALL never change read_bus.
REQ-023 Simultaneous load_valid and MEMORY_WRITE to the same address: load SHALL win and the CPU write SHALL be dropped (not counted); different addresses: both SHALL complete in that cycle.
REQ-024 Read and load to the same address in the same cycle: read_bus SHALL return the old value.
REQ-025 Accepted CPU write with addr_bus==IO_OUT_ADDR SHALL also update io_out to write_bus the same edge; loader writes SHALL not touch io_out.
REQ-026 write_count SHALL increment per accepted CPU write and saturate at 8'hFF.
REQ-027 Reads of IO_OUT_ADDR SHALL return array contents, not io_out.

Reset
REQ-028 RESET high at any edge, including mid-CLEAR or mid-access, SHALL force: state CLEAR (READY if CLEAR_ON_RESET==0), clear_ptr 0, read_bus 8'h00, io_out 8'h00, write_count 8'h00, mem_ready 0.
REQ-029 Array contents SHALL not be reset directly; only the CLEAR sweep zeroes them.
REQ-030 A write requested in the reset cycle SHALL be discarded.

Structure
REQ-031 MEMORY_FLAG_TYPE, DEFAULT_TYPE, REGSIZE and the new MEMORY_STATE_TYPE SHALL live in the shared typedef_collection package.
REQ-032 The storage plus its single write port mux SHALL be sub-module memory_array (ports: CLOCK, we, waddr, wdata, raddr, rdata); FSM, loader arbitration and counters stay in memory_responder.

Verification
REQ-033 Reset then hold ctrl_bus=MEMORY_STAY -> mem_ready rises exactly 256 cycles after RESET falls; read of any address then returns 8'h00.
REQ-034 Load 8'h03 at 8'h10, then MEMORY_READ addr 8'h10 -> read_bus==8'h03 exactly one cycle later, held through subsequent MEMORY_STAY.
REQ-035 MEMORY_WRITE addr 8'hFF data 8'h5A -> io_out==8'h5A next cycle, write_count==1; read 8'hFF returns 8'h5A.
REQ-036 Same cycle load (8'h20,8'hAA) and MEMORY_WRITE (8'h20,8'h55) -> read 8'h20 returns 8'hAA, write_count unchanged.
REQ-037 RESET asserted at clear_ptr==8'h80 -> mem_ready low, sweep restarts from 0, ready after another 256 cycles; io_out and write_count 0.
REQ-038 300 MEMORY_WRITE cycles -> write_count saturates at 8'hFF.

Source files
------------

// File: rtl/typedef_collection.sv
// Types shared by the CPU-facing memory blocks: data word, bus command and responder state.
package typedef_collection;

  localparam int unsigned REGSIZE = 8;

  typedef logic [REGSIZE-1:0] DEFAULT_TYPE;

  typedef enum logic [1:0] {
    MEMORY_STAY  = 2'b00,
    MEMORY_READ  = 2'b01,
    MEMORY_WRITE = 2'b10
  } MEMORY_FLAG_TYPE;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } MEMORY_STATE_TYPE;

endpackage

// File: rtl/memory_responder_array.sv
// Word storage with an asynchronous read port and one muxed write port;
// lane 0 (loader) overrides lane 1 (CPU / clear sweep) when both hit one word.
module memory_array
  import typedef_collection::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic                   CLOCK,
  input  logic [1:0]             we,
  input  logic [1:0][AW-1:0]     waddr,
  input  DEFAULT_TYPE [1:0]      wdata,
  input  logic [AW-1:0]          raddr,
  output DEFAULT_TYPE            rdata
);

  DEFAULT_TYPE mem [DEPTH];

  always_ff @(posedge CLOCK) begin
    if (we[1]) mem[waddr[1]] <= wdata[1];
    if (we[0]) mem[waddr[0]] <= wdata[0];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_responder.sv
// CPU memory responder: post-reset clear sweep, registered reads, loader port,
// memory-mapped output register and a saturating accepted-write counter.
module memory_responder
  import typedef_collection::*;
#(
  parameter int unsigned MEM_DEPTH      = 256,
  parameter DEFAULT_TYPE IO_OUT_ADDR    = 8'hFF,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  MEMORY_FLAG_TYPE ctrl_bus,
  input  DEFAULT_TYPE     addr_bus,
  input  DEFAULT_TYPE     write_bus,
  output DEFAULT_TYPE     read_bus,
  input  logic            load_valid,
  input  logic [7:0]      load_addr,
  input  logic [7:0]      load_data,
  output logic            mem_ready,
  output logic [7:0]      io_out,
  output logic [7:0]      write_count
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Out-of-range addresses alias back into the array.
  function automatic logic [AW-1:0] wrap(input logic [7:0] a);
    return AW'(32'(a) % MEM_DEPTH);
  endfunction

  MEMORY_STATE_TYPE        state;
  logic [AW-1:0]           clear_ptr;
  logic [AW-1:0]           cpu_idx_c;
  logic [AW-1:0]           load_idx_c;
  logic                    load_we_c;
  logic                    cpu_we_c;
  logic                    clear_we_c;
  logic [1:0]              we_c;
  logic [1:0][AW-1:0]      waddr_c;
  DEFAULT_TYPE [1:0]       wdata_c;
  DEFAULT_TYPE             rdata_c;

  // Write arbitration: a loader hit on the CPU's word drops the CPU write.
  always_comb begin
    cpu_idx_c  = wrap(addr_bus);
    load_idx_c = wrap(load_addr);
    load_we_c  = !RESET && (state == READY) && load_valid;
    cpu_we_c   = !RESET && (state == READY) && (ctrl_bus == MEMORY_WRITE) &&
                 !(load_valid && (load_idx_c == cpu_idx_c));
    clear_we_c = !RESET && (state == CLEAR);
    we_c       = {clear_we_c | cpu_we_c, load_we_c};
    waddr_c[1] = clear_we_c ? clear_ptr : cpu_idx_c;
    wdata_c[1] = clear_we_c ? DEFAULT_TYPE'(0) : write_bus;
    waddr_c[0] = load_idx_c;
    wdata_c[0] = load_data;
  end

  memory_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_array (
    .CLOCK (CLOCK),
    .we    (we_c),
    .waddr (waddr_c),
    .wdata (wdata_c),
    .raddr (cpu_idx_c),
    .rdata (rdata_c)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= CLEAR_ON_RESET ? CLEAR : READY;
      clear_ptr   <= '0;
      read_bus    <= '0;
      io_out      <= '0;
      write_count <= '0;
      mem_ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clear_ptr == AW'(MEM_DEPTH - 1)) begin
            state     <= READY;
            mem_ready <= 1'b1;
            clear_ptr <= '0;
          end else begin
            clear_ptr <= clear_ptr + AW'(1);
          end
        end
        READY: begin
          mem_ready <= 1'b1;
          if (ctrl_bus == MEMORY_READ) read_bus <= rdata_c;
          if (cpu_we_c) begin
            if (write_count != 8'hFF) write_count <= write_count + 8'd1;
            if (addr_bus == IO_OUT_ADDR) io_out <= write_bus;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Randomized scoreboard bench for memory_responder against a behavioural array model.
module tb_memory_responder;
  import typedef_collection::*;

  logic            CLOCK = 1'b0;
  logic            RESET = 1'b1;
  MEMORY_FLAG_TYPE ctrl_bus = MEMORY_STAY;
  logic [7:0]      addr_bus = '0;
  logic [7:0]      write_bus = '0;
  logic [7:0]      read_bus;
  logic            load_valid = 1'b0;
  logic [7:0]      load_addr = '0;
  logic [7:0]      load_data = '0;
  logic            mem_ready;
  logic [7:0]      io_out;
  logic [7:0]      write_count;

  memory_responder dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .ctrl_bus    (ctrl_bus),
    .addr_bus    (addr_bus),
    .write_bus   (write_bus),
    .read_bus    (read_bus),
    .load_valid  (load_valid),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .mem_ready   (mem_ready),
    .io_out      (io_out),
    .write_count (write_count)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         due;
    logic [7:0] rd;
    logic [7:0] io;
    logic [7:0] wc;
    logic       rdy;
  } exp_t;
  exp_t sb[$];

  // Behavioural model: plain array plus "still sweeping" flag.
  logic [7:0] m_mem [256];
  bit         m_on = 0;
  bit         m_clearing = 0;
  int         m_ptr = 0;
  logic [7:0] m_rd = '0;
  logic [7:0] m_io = '0;
  int         m_wc = 0;
  logic       m_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input MEMORY_FLAG_TYPE c, input logic [7:0] a, input logic [7:0] wd,
                      input logic lv, input logic [7:0] la, input logic [7:0] ld,
                      input logic rst);
    logic [7:0] old;
    @(posedge CLOCK);
    #2;
    ctrl_bus = c; addr_bus = a; write_bus = wd;
    load_valid = lv; load_addr = la; load_data = ld; RESET = rst;
    if (rst) m_on = 1;
    if (!m_on) return;
    if (rst) begin
      m_clearing = 1; m_ptr = 0; m_rd = '0; m_io = '0; m_wc = 0; m_rdy = 1'b0;
    end else if (m_clearing) begin
      m_mem[m_ptr] = 8'h00;
      m_ptr++;
      if (m_ptr == 256) begin
        m_clearing = 0;
        m_rdy = 1'b1;
      end
    end else begin
      old = m_mem[a];
      if (c == MEMORY_READ) m_rd = old;
      if (lv) m_mem[la] = ld;
      if (c == MEMORY_WRITE && !(lv && la == a)) begin
        m_mem[a] = wd;
        if (m_wc < 255) m_wc++;
        if (a == 8'hFF) m_io = wd;
      end
    end
    sb.push_back('{cyc + 1, m_rd, m_io, 8'(m_wc), m_rdy});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(MEMORY_STAY, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Sweep with noisy bus traffic that must be ignored; measures edges to mem_ready.
  task automatic wait_ready(input string name);
    int rel;
    int n;
    step(MEMORY_STAY, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    rel = cyc;
    n = 0;
    while (!mem_ready && n < 400) begin
      if (n < 240)
        step(MEMORY_FLAG_TYPE'(2'($urandom_range(0, 3))), 8'($urandom), 8'($urandom),
             1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      else
        idle(1);
      n++;
    end
    chk(name, cyc - rel, 256);
  endtask

  function automatic logic [7:0] pick_addr();
    logic [7:0] a;
    if ($urandom_range(0, 1) == 0) a = 8'hF8 | 8'($urandom_range(0, 7));
    else a = 8'($urandom);
    return a;
  endfunction

  // Monitor: every expected entry is compared on the negedge of its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) begin
          checks++;
          failures++;
          $display("FAIL sb_late due=%0d cyc=%0d", e.due, cyc);
        end else begin
          chk("read_bus", read_bus, e.rd);
          chk("io_out", io_out, e.io);
          chk("write_count", write_count, e.wc);
          chk("mem_ready", mem_ready, e.rdy);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic [7:0] la;
    step(MEMORY_STAY, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    step(MEMORY_WRITE, 8'hFF, 8'h99, 1'b1, 8'h01, 8'h11, 1'b1);
    wait_ready("ready_latency_first");

    // Every word swept to zero.
    for (int i = 0; i < 6; i++) step(MEMORY_READ, 8'($urandom), 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    step(MEMORY_READ, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1);

    // Loader write then latency-1 read, held through idle.
    step(MEMORY_STAY, 8'h00, 8'h00, 1'b1, 8'h10, 8'h03, 1'b0);
    step(MEMORY_READ, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(3);

    // Output register write and readback from the array.
    step(MEMORY_WRITE, 8'hFF, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b0);
    step(MEMORY_READ, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1);

    // Loader beats CPU on the same word; CPU write not counted.
    step(MEMORY_WRITE, 8'h20, 8'h55, 1'b1, 8'h20, 8'hAA, 1'b0);
    step(MEMORY_READ, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    // Different addresses: both land; read-vs-load same word returns old value.
    step(MEMORY_WRITE, 8'h30, 8'h31, 1'b1, 8'h40, 8'h41, 1'b0);
    step(MEMORY_READ, 8'h40, 8'h00, 1'b1, 8'h40, 8'hEE, 1'b0);
    step(MEMORY_READ, 8'h40, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    step(MEMORY_READ, 8'h30, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1);

    // Randomized traffic over a small hot region to force collisions.
    for (int i = 0; i < 400; i++) begin
      a = pick_addr();
      la = ($urandom_range(0, 2) == 0) ? a : pick_addr();
      step(MEMORY_FLAG_TYPE'(2'($urandom_range(0, 3))), a, 8'($urandom),
           ($urandom_range(0, 3) == 0), la, 8'($urandom), 1'b0);
    end

    // Counter saturation.
    for (int i = 0; i < 300; i++)
      step(MEMORY_WRITE, 8'($urandom), 8'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
    idle(2);

    // Reset mid-sweep at clear pointer 0x80 restarts the sweep.
    step(MEMORY_STAY, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    step(MEMORY_STAY, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(127);
    step(MEMORY_WRITE, 8'hFF, 8'h77, 1'b0, 8'h00, 8'h00, 1'b1);
    wait_ready("ready_latency_restart");
    step(MEMORY_READ, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    step(MEMORY_WRITE, 8'hFF, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b0);
    // Reset in the middle of access traffic discards the write in that cycle.
    step(MEMORY_WRITE, 8'hFF, 8'hC3, 1'b0, 8'h00, 8'h00, 1'b1);
    wait_ready("ready_latency_midaccess");
    step(MEMORY_READ, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(3);

    repeat (2) @(posedge CLOCK);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
